// File: rtl/pipe_pkg.sv
// Shared constants and types for the RV32I front-end pipeline registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stall_regs_if.sv
// Fetch/decode-side bus of the front-end pipeline registers.
interface pipe_stall_regs_if #(
  parameter int W   = 32,
  parameter int R   = 5,
  parameter int C   = 8,
  parameter int CNT = 16
);
  logic         stall, flush;
  logic [W-1:0] redirect_pc, imem_instr;
  logic [C-1:0] id_ctrl;
  logic         id_memRead;
  logic [R-1:0] id_rs1, id_rs2, id_rd;
  logic [W-1:0] id_rs1_data, id_rs2_data, id_imm;

  logic [W-1:0]   pc, if_id_pc, if_id_instr;
  logic           if_id_valid;
  logic [W-1:0]   id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [C-1:0]   id_ex_ctrl;
  logic           id_ex_memRead;
  logic [R-1:0]   id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic           id_ex_valid;
  logic [CNT-1:0] stall_count;

  modport slave (
    input  stall, flush, redirect_pc, imem_instr, id_ctrl, id_memRead,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    output pc, if_id_pc, if_id_instr, if_id_valid, id_ex_pc, id_ex_rs1_data,
           id_ex_rs2_data, id_ex_imm, id_ex_ctrl, id_ex_memRead, id_ex_rs1,
           id_ex_rs2, id_ex_rd, id_ex_valid, stall_count
  );

  modport master (
    output stall, flush, redirect_pc, imem_instr, id_ctrl, id_memRead,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    input  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_pc, id_ex_rs1_data,
           id_ex_rs2_data, id_ex_imm, id_ex_ctrl, id_ex_memRead, id_ex_rs1,
           id_ex_rs2, id_ex_rd, id_ex_valid, stall_count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async reset value, hold enable, sync clear-to-value.
module pipe_stage_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over hold so a squash is never lost behind a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= RST_VAL;
    else if (clr)   q <= CLR_VAL;
    else if (!hold) q <= d;
  end
endmodule

// File: rtl/pipe_stall_regs.sv
// PC, IF/ID and ID/EX registers with load-use stall, branch flush and stall counter.
module pipe_stall_regs
  import pipe_pkg::*;
#(
  parameter int                       WORD_BITWIDTH    = 32,
  parameter int                       REG_NUM_BITWIDTH = 5,
  parameter int                       CTRL_BITWIDTH    = 8,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC         = DEFAULT_RESET_PC[WORD_BITWIDTH-1:0],
  parameter int                       CNT_BITWIDTH     = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_regs_if.slave  bus
);
  localparam int W = WORD_BITWIDTH;
  localparam int R = REG_NUM_BITWIDTH;
  localparam int C = CTRL_BITWIDTH;

  localparam int IFID_W = 2*W + 1;
  localparam int IDEX_W = 4*W + C + 1 + 3*R + 1;

  localparam logic [IFID_W-1:0] IFID_EMPTY = {{W{1'b0}}, NOP_INSTR[W-1:0], 1'b0};
  // bubble: everything zero, memRead=0 and rd=0 so it cannot re-trigger a stall
  localparam logic [IDEX_W-1:0] IDEX_BUBBLE =
    {{(4*W){1'b0}}, C'(BUBBLE_CTRL), 1'b0, {(3*R){1'b0}}, 1'b0};

  logic [W-1:0]            pc_q;
  logic [CNT_BITWIDTH-1:0] cnt_q;
  logic [IFID_W-1:0]       ifid_q;
  logic [IDEX_W-1:0]       idex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc_q <= RESET_PC;
    else if (bus.flush) pc_q <= {bus.redirect_pc[W-1:2], 2'b00};
    else if (!bus.stall) pc_q <= pc_q + W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        cnt_q <= '0;
    else if (bus.stall && !bus.flush && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
  end

  pipe_stage_reg #(.WIDTH(IFID_W), .RST_VAL(IFID_EMPTY), .CLR_VAL(IFID_EMPTY)) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .hold (bus.stall),
    .clr  (bus.flush),
    .d    ({pc_q, bus.imem_instr, 1'b1}),
    .q    (ifid_q)
  );

  pipe_stage_reg #(.WIDTH(IDEX_W), .RST_VAL(IDEX_BUBBLE), .CLR_VAL(IDEX_BUBBLE)) u_id_ex (
    .clk  (clk),
    .rst  (rst),
    .hold (1'b0),
    .clr  (bus.stall | bus.flush),
    .d    ({bus.if_id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm, bus.id_ctrl,
            bus.id_memRead, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.if_id_valid}),
    .q    (idex_q)
  );

  assign bus.pc          = pc_q;
  assign bus.stall_count = cnt_q;
  assign {bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} = ifid_q;
  assign {bus.id_ex_pc, bus.id_ex_rs1_data, bus.id_ex_rs2_data, bus.id_ex_imm, bus.id_ex_ctrl,
          bus.id_ex_memRead, bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd, bus.id_ex_valid} = idex_q;

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Directed + random bench for pipe_stall_regs against a cycle-level reference model.
module tb_pipe_stall_regs;
  localparam int W = 32, R = 5, C = 8, CNT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_regs_if #(.W(W), .R(R), .C(C), .CNT(CNT)) bus ();

  pipe_stall_regs #(
    .WORD_BITWIDTH(W), .REG_NUM_BITWIDTH(R), .CTRL_BITWIDTH(C),
    .RESET_PC(32'h0), .CNT_BITWIDTH(CNT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // reference state
  logic [31:0] m_pc, m_ifpc, m_ifi, m_expc, m_exr1d, m_exr2d, m_eximm;
  logic        m_ifv, m_exmr, m_exv;
  logic [7:0]  m_exctrl;
  logic [4:0]  m_exrs1, m_exrs2, m_exrd;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idex_bubble();
    m_expc = 0; m_exr1d = 0; m_exr2d = 0; m_eximm = 0; m_exctrl = 0;
    m_exmr = 0; m_exrs1 = 0; m_exrs2 = 0; m_exrd = 0; m_exv = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 0; m_ifi = 32'h0000_0013; m_ifv = 0; m_cnt = 0;
    idex_bubble();
  endtask

  task automatic model_clock();
    if (bus.flush) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      m_ifpc = 0; m_ifi = 32'h0000_0013; m_ifv = 0;
      idex_bubble();
    end else if (bus.stall) begin
      idex_bubble();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_expc = m_ifpc; m_exv = m_ifv;
      m_exr1d = bus.id_rs1_data; m_exr2d = bus.id_rs2_data; m_eximm = bus.id_imm;
      m_exctrl = bus.id_ctrl; m_exmr = bus.id_memRead;
      m_exrs1 = bus.id_rs1; m_exrs2 = bus.id_rs2; m_exrd = bus.id_rd;
      m_ifpc = m_pc; m_ifi = bus.imem_instr; m_ifv = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_instr", bus.if_id_instr, m_ifi);
    chk("if_id_valid", bus.if_id_valid, m_ifv);
    chk("id_ex_pc", bus.id_ex_pc, m_expc);
    chk("id_ex_rs1_data", bus.id_ex_rs1_data, m_exr1d);
    chk("id_ex_rs2_data", bus.id_ex_rs2_data, m_exr2d);
    chk("id_ex_imm", bus.id_ex_imm, m_eximm);
    chk("id_ex_ctrl", bus.id_ex_ctrl, m_exctrl);
    chk("id_ex_memRead", bus.id_ex_memRead, m_exmr);
    chk("id_ex_rs1", bus.id_ex_rs1, m_exrs1);
    chk("id_ex_rs2", bus.id_ex_rs2, m_exrs2);
    chk("id_ex_rd", bus.id_ex_rd, m_exrd);
    chk("id_ex_valid", bus.id_ex_valid, m_exv);
    chk("stall_count", bus.stall_count, m_cnt);
  endtask

  task automatic rand_inputs();
    bus.imem_instr  = $urandom;
    bus.id_ctrl     = 8'($urandom);
    bus.id_memRead  = 1'($urandom);
    bus.id_rs1      = 5'($urandom);
    bus.id_rs2      = 5'($urandom);
    bus.id_rd       = 5'($urandom);
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imm      = $urandom;
  endtask

  task automatic step(input logic s, input logic f, input logic [31:0] rp, input bit full);
    bus.stall = s; bus.flush = f; bus.redirect_pc = rp;
    rand_inputs();
    @(posedge clk);
    model_clock();
    #1;
    if (full) check_all();
  endtask

  logic [31:0] held_pc;

  initial begin
    bus.stall = 0; bus.flush = 0; bus.redirect_pc = 0;
    rand_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_if_id_instr", bus.if_id_instr, 32'h0000_0013);
    #2 rst = 1'b0;

    // free-running fetch
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1);
      chk("adv_pc", bus.pc, 32'(4 * i));
      chk("adv_if_id_valid", bus.if_id_valid, 1'b1);
      chk("adv_id_ex_valid", bus.id_ex_valid, (i >= 2) ? 1'b1 : 1'b0);
    end
    step(0, 0, 0, 1);

    // single load-use stall at pc=0x10
    step(1, 0, 0, 1);
    chk("stall_pc", bus.pc, 32'h10);
    chk("stall_id_ex_valid", bus.id_ex_valid, 1'b0);
    chk("stall_memRead", bus.id_ex_memRead, 1'b0);
    chk("stall_rd", bus.id_ex_rd, 5'd0);
    chk("stall_count1", bus.stall_count, 16'd1);
    step(0, 0, 0, 1);
    chk("post_stall_pc", bus.pc, 32'h14);

    // flush with misaligned target
    step(0, 1, 32'h103, 1);
    chk("flush_pc", bus.pc, 32'h100);
    chk("flush_if_valid", bus.if_id_valid, 1'b0);
    chk("flush_if_instr", bus.if_id_instr, 32'h13);
    chk("flush_ex_valid", bus.id_ex_valid, 1'b0);
    chk("flush_count", bus.stall_count, 16'd1);

    // flush beats stall
    step(1, 1, 32'h40, 1);
    chk("sf_pc", bus.pc, 32'h40);
    chk("sf_if_valid", bus.if_id_valid, 1'b0);
    chk("sf_ex_valid", bus.id_ex_valid, 1'b0);
    chk("sf_count", bus.stall_count, 16'd1);

    // long stall saturates the counter
    held_pc = m_pc;
    for (int i = 0; i < (1 << CNT) + 5; i++) begin
      step(1, 0, 0, 0);
      if (i % 1024 == 0) chk("long_stall_pc", bus.pc, held_pc);
    end
    check_all();
    chk("sat_count", bus.stall_count, 16'hFFFF);

    // pc wraparound
    step(0, 1, 32'hFFFF_FFFE, 1);
    chk("wrap_pre_pc", bus.pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc", bus.pc, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, 1);

    // async reset in the middle of a stall
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midrst_pc", bus.pc, 32'h0);
    @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;
    step(0, 0, 0, 1);
    chk("after_rst_pc", bus.pc, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
